// File: rtl/ldpc_encode_sequencer_pkg.sv
// Shared types, limits and helpers for the LDPC encode frame sequencer.
// Consumed by the sequencer, its bus interface and anything driving a frame.
package ldpc_encode_sequencer_pkg;

    localparam int unsigned COL_W = 5;
    localparam int unsigned ROW_W = 6;
    localparam int unsigned ZC_W  = 9;
    localparam int unsigned ILS_W = 3;

    localparam int unsigned BG1_MSG_COL_COUNT = 22;
    localparam int unsigned BG2_MSG_COL_COUNT = 10;
    localparam int unsigned BG1_ROW_COUNT     = 46;
    localparam int unsigned BG2_ROW_COUNT     = 42;
    localparam int unsigned EXT_ROW_START     = 4;

    typedef enum logic [1:0] {
        BG_NONE = 2'd0,
        BG1     = 2'd1,
        BG2     = 2'd2
    } BG_Type;

    // Sequencer states kept as plain encoded constants for compatibility with older blocks.
    typedef logic [2:0] enc_seq_state_t;
    localparam enc_seq_state_t ST_IDLE     = 3'd0;
    localparam enc_seq_state_t ST_CHECK    = 3'd1;
    localparam enc_seq_state_t ST_LAMBDA   = 3'd2;
    localparam enc_seq_state_t ST_GAP_WAIT = 3'd3;
    localparam enc_seq_state_t ST_EXT      = 3'd4;
    localparam enc_seq_state_t ST_DONE     = 3'd5;
    localparam enc_seq_state_t ST_ERR      = 3'd6;

    typedef struct packed {
        BG_Type            bg;
        logic [ZC_W-1:0]   zc;
        logic [ILS_W-1:0]  ils;
    } frame_cfg_t;

    // A frame is encodable only with a known base graph and 1 <= zc <= max_zc.
    function automatic logic cfg_is_legal(input frame_cfg_t cfg, input logic [ZC_W-1:0] max_zc);
        logic bg_ok;
        logic zc_ok;
        bg_ok = (cfg.bg == BG1) || (cfg.bg == BG2);
        zc_ok = (cfg.zc != '0) && (cfg.zc <= max_zc);
        return bg_ok && zc_ok;
    endfunction

endpackage

// File: rtl/ldpc_encode_sequencer_if.sv
// Frame-level host handshake plus core/extension parity control for the encode sequencer.
interface ldpc_encode_sequencer_if;
    import ldpc_encode_sequencer_pkg::*;

    logic              start;
    logic              abort;
    BG_Type            bg_in;
    logic [ZC_W-1:0]   zc_in;
    logic [ILS_W-1:0]  ils_in;
    logic              msg_col_valid;
    logic              gap_eval_done;
    logic              ext_ready;

    logic              busy;
    BG_Type            cfg_bg;
    logic [ZC_W-1:0]   cfg_zc;
    logic [ILS_W-1:0]  cfg_ils;
    logic [COL_W-1:0]  col_idx;
    logic              lambda_eval_en;
    logic [ROW_W-1:0]  ext_row_idx;
    logic              ext_row_valid;
    logic              enc_done;
    logic              enc_error;

    modport master (
        output start, abort, bg_in, zc_in, ils_in,
        output msg_col_valid, gap_eval_done, ext_ready,
        input  busy, cfg_bg, cfg_zc, cfg_ils, col_idx, lambda_eval_en,
        input  ext_row_idx, ext_row_valid, enc_done, enc_error
    );

    modport slave (
        input  start, abort, bg_in, zc_in, ils_in,
        input  msg_col_valid, gap_eval_done, ext_ready,
        output busy, cfg_bg, cfg_zc, cfg_ils, col_idx, lambda_eval_en,
        output ext_row_idx, ext_row_valid, enc_done, enc_error
    );

endinterface

// File: rtl/ldpc_encode_sequencer.sv
// Sequences one LDPC encode frame: config check, message-column lambda pass,
// gap wait with timeout, then extension-row issue to the extension-parity unit.
module ldpc_encode_sequencer
    import ldpc_encode_sequencer_pkg::*;
#(
    parameter int unsigned MAX_ZC      = 384,
    parameter int unsigned GAP_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ldpc_encode_sequencer_if.slave bus
);

    localparam int unsigned TO_W = $clog2(GAP_TIMEOUT + 1);

    enc_seq_state_t    state_q, state_d;
    frame_cfg_t        cfg_q, cfg_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              busy_q, busy_d;
    logic              ext_row_valid_q, ext_row_valid_d;
    logic              enc_done_q, enc_done_d;
    logic              enc_error_q, enc_error_d;

    logic [COL_W-1:0]  last_col;
    logic [ROW_W-1:0]  last_row;
    logic              cfg_legal;

    // Per-frame limits from the latched base graph; unknown BG never leaves CHECK.
    always_comb begin
        last_col = COL_W'(BG2_MSG_COL_COUNT - 1);
        last_row = ROW_W'(BG2_ROW_COUNT - 1);
        if (cfg_q.bg == BG1) begin
            last_col = COL_W'(BG1_MSG_COL_COUNT - 1);
            last_row = ROW_W'(BG1_ROW_COUNT - 1);
        end
    end

    assign cfg_legal = cfg_is_legal(cfg_q, ZC_W'(MAX_ZC));

    // Next state, counters and registered-output decode.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        col_d   = col_q;
        row_d   = row_q;
        to_d    = to_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cfg_d   = '{bg: bus.bg_in, zc: bus.zc_in, ils: bus.ils_in};
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cfg_legal) begin
                    state_d = ST_LAMBDA;
                    col_d   = '0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_LAMBDA: begin
                if (bus.msg_col_valid) begin
                    if (col_q == last_col) begin
                        state_d = ST_GAP_WAIT;
                        col_d   = '0;
                        to_d    = '0;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_GAP_WAIT: begin
                // A done landing on the final allowed cycle still counts as success.
                if (bus.gap_eval_done) begin
                    state_d = ST_EXT;
                    row_d   = ROW_W'(EXT_ROW_START);
                    to_d    = '0;
                end else if (to_q == TO_W'(GAP_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    to_d    = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_EXT: begin
                if (bus.ext_ready) begin
                    if (row_q == last_row) begin
                        state_d = ST_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                col_d   = '0;
                row_d   = '0;
                to_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever transition was chosen and suppresses any pulse.
        if (bus.abort) begin
            state_d = ST_IDLE;
            col_d   = '0;
            row_d   = '0;
            to_d    = '0;
        end

        busy_d          = (state_d != ST_IDLE);
        ext_row_valid_d = (state_d == ST_EXT);
        enc_done_d      = (state_d == ST_DONE);
        enc_error_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cfg_q           <= '0;
            col_q           <= '0;
            row_q           <= '0;
            to_q            <= '0;
            busy_q          <= 1'b0;
            ext_row_valid_q <= 1'b0;
            enc_done_q      <= 1'b0;
            enc_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cfg_q           <= cfg_d;
            col_q           <= col_d;
            row_q           <= row_d;
            to_q            <= to_d;
            busy_q          <= busy_d;
            ext_row_valid_q <= ext_row_valid_d;
            enc_done_q      <= enc_done_d;
            enc_error_q     <= enc_error_d;
        end
    end

    // The evaluator enable follows msg_col_valid within the same cycle.
    assign bus.lambda_eval_en = (state_q == ST_LAMBDA) && bus.msg_col_valid;

    assign bus.busy          = busy_q;
    assign bus.cfg_bg        = cfg_q.bg;
    assign bus.cfg_zc        = cfg_q.zc;
    assign bus.cfg_ils       = cfg_q.ils;
    assign bus.col_idx       = col_q;
    assign bus.ext_row_idx   = row_q;
    assign bus.ext_row_valid = ext_row_valid_q;
    assign bus.enc_done      = enc_done_q;
    assign bus.enc_error     = enc_error_q;

endmodule
